block_scroller: RTL and testbench
=================================

BLOCK_SCROLLER -- requirements
Module: block_scroller

Interface
REQ-001 The module SHALL have parameter NUM_BLOCKS, default 8, meaning the number of entries in the block table.
REQ-002 The module SHALL have parameter TILE, default 32, meaning the block edge length in pixels.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port x, input, 10 bits: current VGA pixel column.
REQ-006 The module SHALL have port y, input, 10 bits: current VGA pixel row.
REQ-007 The module SHALL have port frame_tick, input, 1 bit: one-cycle pulse during vertical blank.
REQ-008 The module SHALL have port scroll_en, input, 1 bit: when high, scrolling advances on frame_tick.
REQ-009 The module SHALL have port speed, input, 2 bits: scroll step in pixels per frame, 0..3.
REQ-010 The module SHALL have port enable, output, 1 bit: the pixel lies inside a block.
REQ-011 The module SHALL have ports diff_x and diff_y, output, 10 bits each: pixel offset inside the hit block, 0..TILE-1.
REQ-012 The module SHALL have ports pos_x and pos_y, output, 10 bits each: screen position of the hit block's top-left corner.
REQ-013 The module SHALL have port scroll_x, output, 10 bits: current horizontal scroll offset.

Function
REQ-014 Scroll counter SHALL update only on a cycle with frame_tick=1 and scroll_en=1: scroll_x <= scroll_x + speed, modulo 1024 (natural 10-bit wrap).
REQ-015 With frame_tick=0 or scroll_en=0, scroll_x SHALL hold.
REQ-016 Block i has world coordinates (bx_i, by_i) from the package table; its screen column SHALL be sx_i = (bx_i - scroll_x) mod 1024; pos_y = by_i (no vertical scroll).
REQ-017 Block i SHALL be hit when (x - sx_i) mod 1024 < TILE and by_i <= y < by_i + TILE (unsigned; by_i + TILE computed at 11 bits).
REQ-018 Pipeline stage 1 SHALL register x, y and a snapshot of scroll_x.
REQ-019 Stage 2 SHALL evaluate all blocks against the stage-1 snapshot and register the outputs. Total latency from x/y to enable/diff/pos SHALL be exactly 2 cycles, one result per cycle, with no stalls.
REQ-020 On multiple hits, the lowest block index SHALL win.
REQ-021 On a hit, enable=1, diff_x=(x - sx_i) mod 1024, diff_y=y - by_i, pos_x=sx_i, pos_y=by_i.
REQ-022 On no hit, enable=0 and diff_x, diff_y, pos_x, pos_y SHALL all be 0.
REQ-023 If frame_tick coincides with a pixel sample, that pixel SHALL use the pre-update scroll_x (the snapshot).
REQ-024 Blocks straddling the 1023->0 wrap SHALL be hit on both visible fragments per the modular rule in REQ-017.

Reset
REQ-025 When rst=1 at a clock edge, scroll_x, both pipeline stages, enable, diff_x, diff_y, pos_x and pos_y SHALL all become 0.
REQ-026 Reset asserted mid-frame SHALL force enable=0 from the following cycle. The first valid output after rst deasserts SHALL appear 2 cycles after the first sampled x/y.

Structure
REQ-027 Package block_pkg SHALL hold TILE_SIZE, NUM_BLOCKS, typedef block_t (10-bit bx, 10-bit by) and the constant block table.
REQ-028 Per-block comparison SHALL live in sub-module block_hit. It is combinational, instantiated NUM_BLOCKS times, and outputs hit, diff_x, diff_y and sx.
REQ-029 The outputs diff_x, diff_y and enable SHALL drive the downstream tile renderer's sprite index and enable directly.

Verification (table: block0=(100,400), block1=(110,400))
REQ-030 Hit: scroll_x=0, x=105, y=410 -> two cycles later enable=1, diff_x=5, diff_y=10, pos_x=100, pos_y=400.
REQ-031 Overlap priority: x=115, y=400 -> enable=1, diff_x=15, pos_x=100 (block0).
REQ-032 Miss: x=142, y=410 -> enable=0, all offsets 0. Edge case: x=141, y=431 -> enable=1, diff_x=31, diff_y=31.
REQ-033 Scroll: speed=3, scroll_en=1, 4 frame_ticks -> scroll_x=12. Then x=90, y=400 -> enable=1, pos_x=88, diff_x=2.
REQ-034 Wrap and hold: scroll_x=1022, speed=3, one tick -> scroll_x=1. With scroll_en=0, 5 ticks -> scroll_x stays 1.
REQ-035 Reset mid-stream: hit pixel streaming, rst=1 for one cycle -> next cycle enable=0 and scroll_x=0; hits resume 2 cycles after the first post-reset sample.

Source files
------------

// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - block geometry, block record type and the constant block table.
package block_pkg;

   localparam int TILE_SIZE  = 32;
   localparam int NUM_BLOCKS = 8;

   typedef struct packed {
      logic [9:0] bx;
      logic [9:0] by;
   } block_t;

   // World-space block table; block 4 straddles the 1023->0 column wrap at zero scroll.
   function automatic block_t block_entry(input int idx);
      case (idx)
         0:       return block_t'{bx: 10'd100,  by: 10'd400};
         1:       return block_t'{bx: 10'd110,  by: 10'd400};
         2:       return block_t'{bx: 10'd300,  by: 10'd100};
         3:       return block_t'{bx: 10'd500,  by: 10'd200};
         4:       return block_t'{bx: 10'd1010, by: 10'd50};
         5:       return block_t'{bx: 10'd700,  by: 10'd300};
         6:       return block_t'{bx: 10'd200,  by: 10'd250};
         7:       return block_t'{bx: 10'd600,  by: 10'd420};
         default: return block_t'{bx: 10'd0,    by: 10'd1000};
      endcase
   endfunction

endpackage

// File: rtl/block_hit.sv
// rtl/block_hit.sv - combinational hit test of one pixel against one block.
module block_hit
   import block_pkg::*;
#(
   parameter int TILE = TILE_SIZE
) (
   input  block_t     blk,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [9:0] scroll,
   output logic       hit,
   output logic [9:0] diff_x,
   output logic [9:0] diff_y,
   output logic [9:0] sx
);

   localparam logic [10:0] TILE_W = 11'(TILE);

   logic [10:0] y_end;

   // All column arithmetic wraps at 10 bits so blocks split across the edge hit on both sides.
   always_comb begin
      sx     = blk.bx - scroll;
      diff_x = x - sx;
      diff_y = y - blk.by;
      y_end  = {1'b0, blk.by} + TILE_W;
      hit    = ({1'b0, diff_x} < TILE_W) && (y >= blk.by) && ({1'b0, y} < y_end);
   end

endmodule

// File: rtl/block_scroller.sv
// rtl/block_scroller.sv - horizontally scrolling block field, two-stage pixel hit pipeline.
module block_scroller #(
   parameter int NUM_BLOCKS = 8,
   parameter int TILE       = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       frame_tick,
   input  logic       scroll_en,
   input  logic [1:0] speed,
   output logic       enable,
   output logic [9:0] diff_x,
   output logic [9:0] diff_y,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [9:0] scroll_x
);

   import block_pkg::*;

   logic [9:0] x_q;
   logic [9:0] y_q;
   logic [9:0] scroll_q;

   logic [NUM_BLOCKS-1:0] hit;
   logic [9:0]            dx_a [NUM_BLOCKS];
   logic [9:0]            dy_a [NUM_BLOCKS];
   logic [9:0]            sx_a [NUM_BLOCKS];
   logic [9:0]            by_a [NUM_BLOCKS];

   logic       sel_hit;
   logic [9:0] sel_dx;
   logic [9:0] sel_dy;
   logic [9:0] sel_px;
   logic [9:0] sel_py;

   always_ff @(posedge clk) begin
      if (rst) begin
         scroll_x <= '0;
      end else if (frame_tick && scroll_en) begin
         scroll_x <= scroll_x + {8'd0, speed};
      end
   end

   // Stage 1 snapshots scroll_x so a coincident frame_tick does not affect this pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         scroll_q <= '0;
      end else begin
         x_q      <= x;
         y_q      <= y;
         scroll_q <= scroll_x;
      end
   end

   for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_blk
      localparam block_t BLK = block_entry(g);

      assign by_a[g] = BLK.by;

      block_hit #(
         .TILE (TILE)
      ) u_hit (
         .blk    (BLK),
         .x      (x_q),
         .y      (y_q),
         .scroll (scroll_q),
         .hit    (hit[g]),
         .diff_x (dx_a[g]),
         .diff_y (dy_a[g]),
         .sx     (sx_a[g])
      );
   end

   // Descending scan so the lowest-index hit is the last assignment and wins.
   always_comb begin
      sel_hit = 1'b0;
      sel_dx  = '0;
      sel_dy  = '0;
      sel_px  = '0;
      sel_py  = '0;
      for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            sel_hit = 1'b1;
            sel_dx  = dx_a[i];
            sel_dy  = dy_a[i];
            sel_px  = sx_a[i];
            sel_py  = by_a[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable <= 1'b0;
         diff_x <= '0;
         diff_y <= '0;
         pos_x  <= '0;
         pos_y  <= '0;
      end else begin
         enable <= sel_hit;
         diff_x <= sel_dx;
         diff_y <= sel_dy;
         pos_x  <= sel_px;
         pos_y  <= sel_py;
      end
   end

endmodule

// File: tb/tb_block_scroller.sv
// tb/tb_block_scroller.sv - randomized self-checking bench for block_scroller against a world-space model.
module tb_block_scroller;

   import block_pkg::*;

   localparam int NB = 8;
   localparam int TL = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       frame_tick = 1'b0;
   logic       scroll_en = 1'b0;
   logic [1:0] speed = '0;
   logic       enable;
   logic [9:0] diff_x;
   logic [9:0] diff_y;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic [9:0] scroll_x;

   block_scroller #(
      .NUM_BLOCKS (NB),
      .TILE       (TL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .x          (x),
      .y          (y),
      .frame_tick (frame_tick),
      .scroll_en  (scroll_en),
      .speed      (speed),
      .enable     (enable),
      .diff_x     (diff_x),
      .diff_y     (diff_y),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .scroll_x   (scroll_x)
   );

   always #5 clk = ~clk;

   typedef struct {
      int en;
      int dx;
      int dy;
      int px;
      int py;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   int   m_scroll = 0;
   exp_t q[$];

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int wrap(input int v);
      return ((v % 1024) + 1024) % 1024;
   endfunction

   // Screen-space view of the world: scan blocks in index order, first hit wins.
   function automatic exp_t model(input int px, input int py, input int s);
      exp_t r;
      r = '{0, 0, 0, 0, 0};
      for (int i = 0; i < NB; i++) begin
         int bx, by, sx, dx;
         bx = int'(block_entry(i).bx);
         by = int'(block_entry(i).by);
         sx = wrap(bx - s);
         dx = wrap(px - sx);
         if (dx < TL && py >= by && py < by + TL) begin
            r = '{1, dx, py - by, sx, by};
            return r;
         end
      end
      return r;
   endfunction

   task automatic step(input int nx, input int ny, input bit tk, input bit se, input int spd, input bit r);
      exp_t e;
      exp_t z;
      z = '{0, 0, 0, 0, 0};
      @(negedge clk);
      e = q.pop_front();
      check_eq("enable",   enable,   e.en);
      check_eq("diff_x",   diff_x,   e.dx);
      check_eq("diff_y",   diff_y,   e.dy);
      check_eq("pos_x",    pos_x,    e.px);
      check_eq("pos_y",    pos_y,    e.py);
      check_eq("scroll_x", scroll_x, m_scroll);
      x          = 10'(nx);
      y          = 10'(ny);
      frame_tick = tk;
      scroll_en  = se;
      speed      = 2'(spd);
      rst        = r;
      if (r) begin
         q[0] = z;
         q.push_back(model(0, 0, 0));
         m_scroll = 0;
      end else begin
         q.push_back(model(nx % 1024, ny % 1024, m_scroll));
         if (tk && se) m_scroll = (m_scroll + spd) % 1024;
      end
   endtask

   initial begin
      exp_t z;
      z = '{0, 0, 0, 0, 0};
      q.push_back(z);
      q.push_back(z);
      repeat (2) @(negedge clk);

      // Directed hit, overlap priority, miss and far-corner edge at scroll 0.
      step(105, 410, 0, 0, 0, 0);
      step(115, 400, 0, 0, 0, 0);
      step(142, 410, 0, 0, 0, 0);
      check_eq("hit_en", enable, 1);
      check_eq("hit_dx", diff_x, 5);
      check_eq("hit_dy", diff_y, 10);
      check_eq("hit_px", pos_x, 100);
      check_eq("hit_py", pos_y, 400);
      step(141, 431, 0, 0, 0, 0);
      check_eq("prio_dx", diff_x, 15);
      check_eq("prio_px", pos_x, 100);
      step(0, 0, 0, 0, 0, 0);
      check_eq("miss_en", enable, 0);
      check_eq("miss_dx", diff_x, 0);
      check_eq("miss_dy", diff_y, 0);
      step(0, 0, 0, 0, 0, 0);
      check_eq("edge_en", enable, 1);
      check_eq("edge_dx", diff_x, 31);
      check_eq("edge_dy", diff_y, 31);

      // Four ticks at speed 3, then a pixel against the shifted block.
      repeat (4) step(0, 0, 1, 1, 3, 0);
      step(90, 400, 0, 1, 3, 0);
      check_eq("scroll_12", scroll_x, 12);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      check_eq("scr_en", enable, 1);
      check_eq("scr_px", pos_x, 88);
      check_eq("scr_dx", diff_x, 2);

      // Walk to 1022, wrap past 1023, then ticks with scroll_en low must hold.
      repeat (336) step(0, 0, 1, 1, 3, 0);
      step(0, 0, 1, 1, 2, 0);
      step(0, 0, 1, 1, 3, 0);
      check_eq("scroll_1022", scroll_x, 1022);
      repeat (5) step(0, 0, 1, 0, 3, 0);
      check_eq("scroll_wrap_hold", scroll_x, 1);

      // Reset while hits stream through the pipeline.
      repeat (3) step(105, 410, 0, 0, 0, 0);
      step(105, 410, 0, 0, 0, 1);
      step(105, 410, 0, 0, 0, 0);
      check_eq("rst_en", enable, 0);
      check_eq("rst_scroll", scroll_x, 0);
      step(105, 410, 0, 0, 0, 0);
      step(105, 410, 0, 0, 0, 0);
      check_eq("rst_resume", enable, 1);

      // Randomized stream, biased toward block neighbourhoods and the wrap fragment.
      for (int n = 0; n < 3000; n++) begin
         int  px, py, k;
         bit  tk, se, r;
         if ($urandom_range(0, 1) == 0) begin
            px = $urandom_range(0, 1023);
            py = $urandom_range(0, 479);
         end else begin
            k  = $urandom_range(0, NB - 1);
            px = wrap(int'(block_entry(k).bx) - m_scroll + $urandom_range(0, 40) - 4);
            py = int'(block_entry(k).by) + $urandom_range(0, 40) - 4;
            if (py < 0) py = 0;
            py = py % 1024;
         end
         tk = ($urandom_range(0, 7) == 0);
         se = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 199) == 0);
         step(px, py, tk, se, $urandom_range(0, 3), r);
      end
      repeat (2) step(0, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
